// File: rtl/pong_pkg.sv
// Shared key definitions for the pong input path and game FSM.
// Scan codes, key classes and the held-mask bit map.
package pong_pkg;

  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_ESC   = 8'h76;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_1     = 8'h16;
  localparam logic [7:0] SC_2     = 8'h1E;
  localparam logic [7:0] SC_R     = 8'h2D;
  localparam logic [7:0] SC_G     = 8'h34;
  localparam logic [7:0] SC_B     = 8'h32;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_J     = 8'h3B;
  localparam logic [7:0] SC_L     = 8'h4B;

  localparam int HELD_W = 11;

  localparam int HB_ESC   = 10;
  localparam int HB_SPACE = 9;
  localparam int HB_1     = 8;
  localparam int HB_2     = 7;
  localparam int HB_R     = 6;
  localparam int HB_G     = 5;
  localparam int HB_B     = 4;
  localparam int HB_J     = 3;
  localparam int HB_A     = 2;
  localparam int HB_D     = 1;
  localparam int HB_L     = 0;

  typedef enum logic [1:0] {
    CLS_NONE,
    CLS_CTRL,
    CLS_P1,
    CLS_P2
  } key_class_e;

  function automatic key_class_e key_class(
    input logic [7:0] c
  );
    key_class_e k;
    case (c)
      SC_ESC, SC_SPACE, SC_1, SC_2,
      SC_R, SC_G, SC_B: k = CLS_CTRL;
      SC_A, SC_D:       k = CLS_P1;
      SC_J, SC_L:       k = CLS_P2;
      default:          k = CLS_NONE;
    endcase
    return k;
  endfunction

  // One-hot held bit for a code; zero when unmapped.
  function automatic logic [HELD_W-1:0] held_mask(
    input logic [7:0] c
  );
    logic [HELD_W-1:0] m;
    m = '0;
    case (c)
      SC_ESC:   m[HB_ESC]   = 1'b1;
      SC_SPACE: m[HB_SPACE] = 1'b1;
      SC_1:     m[HB_1]     = 1'b1;
      SC_2:     m[HB_2]     = 1'b1;
      SC_R:     m[HB_R]     = 1'b1;
      SC_G:     m[HB_G]     = 1'b1;
      SC_B:     m[HB_B]     = 1'b1;
      SC_J:     m[HB_J]     = 1'b1;
      SC_A:     m[HB_A]     = 1'b1;
      SC_D:     m[HB_D]     = 1'b1;
      SC_L:     m[HB_L]     = 1'b1;
      default:  m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/key_fifo.sv
// Per-player event queue, power-of-two depth.
// Push is accepted when full if a pop happens in the same cycle.
module key_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)
        count <= count + 1'b1;
      else if (do_pop && !do_push)
        count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/key_event_arbiter.sv
// PS/2 set-2 decoder feeding a control slot and two player queues,
// arbitrated to one key event per video frame.
module key_event_arbiter
  import pong_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int REPEAT_EN = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              scan_valid,
  input  logic [7:0]        scan_code,
  input  logic              frame_tick,
  output logic              key_valid,
  output logic [7:0]        key_code,
  output logic [HELD_W-1:0] held,
  output logic [7:0]        drop_count
);

  typedef enum logic [1:0] {
    IDLE,
    BRK,
    EXT,
    EXT_BRK
  } dec_state_e;

  localparam bit REP = (REPEAT_EN != 0);

  dec_state_e        state;
  dec_state_e        state_next;
  logic              make;
  logic              brk;
  key_class_e        cls;
  logic [HELD_W-1:0] mask;
  logic [HELD_W-1:0] held_next;
  logic              was_held;
  logic              ctrl_wr;
  logic              p1_push;
  logic              p2_push;
  logic              ctrl_pend;
  logic [7:0]        ctrl_code;
  logic              rr_p2;
  logic              p1_full;
  logic              p1_empty;
  logic              p2_full;
  logic              p2_empty;
  logic [7:0]        p1_head;
  logic [7:0]        p2_head;
  logic              pick_p1;
  logic              g_ctrl;
  logic              g_p1;
  logic              g_p2;
  logic [7:0]        g_code;
  logic              drop;

  always_comb begin
    state_next = state;
    make       = 1'b0;
    brk        = 1'b0;
    if (scan_valid) begin
      unique case (state)
        IDLE: begin
          if (scan_code == SC_BRK)
            state_next = BRK;
          else if (scan_code == SC_EXT)
            state_next = EXT;
          else
            make = 1'b1;
        end
        BRK: begin
          brk        = 1'b1;
          state_next = IDLE;
        end
        EXT: begin
          state_next = (scan_code == SC_BRK) ? EXT_BRK : IDLE;
        end
        EXT_BRK: state_next = IDLE;
      endcase
    end
  end

  assign cls      = key_class(scan_code);
  assign mask     = held_mask(scan_code);
  assign was_held = |(held & mask);

  always_comb begin
    held_next = held;
    if (make)     held_next = held | mask;
    else if (brk) held_next = held & ~mask;
  end

  // Control keys are edge-only; player keys may repeat.
  assign ctrl_wr = make && (cls == CLS_CTRL) && !was_held;
  assign p1_push = make && (cls == CLS_P1) && (!was_held || REP);
  assign p2_push = make && (cls == CLS_P2) && (!was_held || REP);

  assign pick_p1 = !p1_empty && (!rr_p2 || p2_empty);

  always_comb begin
    g_ctrl = frame_tick && ctrl_pend;
    g_p1   = frame_tick && !ctrl_pend && pick_p1;
    g_p2   = frame_tick && !ctrl_pend && !pick_p1 && !p2_empty;
    g_code = key_code;
    unique case (1'b1)
      g_ctrl:  g_code = ctrl_code;
      g_p1:    g_code = p1_head;
      g_p2:    g_code = p2_head;
      default: g_code = key_code;
    endcase
  end

  assign drop = (p1_push && p1_full && !g_p1) ||
                (p2_push && p2_full && !g_p2);

  key_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_p1 (
    .clock (clock),
    .reset (reset),
    .push  (p1_push),
    .pop   (g_p1),
    .din   (scan_code),
    .dout  (p1_head),
    .full  (p1_full),
    .empty (p1_empty)
  );

  key_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_p2 (
    .clock (clock),
    .reset (reset),
    .push  (p2_push),
    .pop   (g_p2),
    .din   (scan_code),
    .dout  (p2_head),
    .full  (p2_full),
    .empty (p2_empty)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      held       <= '0;
      ctrl_pend  <= 1'b0;
      ctrl_code  <= '0;
      rr_p2      <= 1'b0;
      key_valid  <= 1'b0;
      key_code   <= '0;
      drop_count <= '0;
    end else begin
      state     <= state_next;
      held      <= held_next;
      key_valid <= g_ctrl || g_p1 || g_p2;
      if (g_ctrl || g_p1 || g_p2) key_code <= g_code;
      if (ctrl_wr) begin
        ctrl_pend <= 1'b1;
        ctrl_code <= scan_code;
      end else if (g_ctrl) begin
        ctrl_pend <= 1'b0;
      end
      if (g_p1)      rr_p2 <= 1'b1;
      else if (g_p2) rr_p2 <= 1'b0;
      if (drop && drop_count != 8'hFF)
        drop_count <= drop_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_key_event_arbiter.sv
// Randomized + directed bench; instance 0 queues repeats, instance 1 drops them.
module tb_key_event_arbiter;

  typedef logic [7:0] bq_t[$];

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        scan_valid = 1'b0;
  logic [7:0]  scan_code = 8'h00;
  logic        frame_tick = 1'b0;
  logic        kv [2];
  logic [7:0]  kc [2];
  logic [10:0] hd [2];
  logic [7:0]  dc [2];

  int checks = 0;
  int errors = 0;

  // reference model state
  bq_t        mq1 [2];
  bq_t        mq2 [2];
  bq_t        glog [2];
  int         mpfx [2];
  logic [10:0] mheld [2];
  bit         mctrl_ok [2];
  logic [7:0] mctrl [2];
  bit         mrr [2];
  int         mdrop [2];
  bit         mkv [2];
  logic [7:0] mkc [2];

  always #5 clock = ~clock;

  key_event_arbiter #(.DEPTH(4), .REPEAT_EN(1)) u_rep (
    .clock(clock), .reset(reset),
    .scan_valid(scan_valid), .scan_code(scan_code),
    .frame_tick(frame_tick),
    .key_valid(kv[0]), .key_code(kc[0]),
    .held(hd[0]), .drop_count(dc[0])
  );

  key_event_arbiter #(.DEPTH(4), .REPEAT_EN(0)) u_norep (
    .clock(clock), .reset(reset),
    .scan_valid(scan_valid), .scan_code(scan_code),
    .frame_tick(frame_tick),
    .key_valid(kv[1]), .key_code(kc[1]),
    .held(hd[1]), .drop_count(dc[1])
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic int kcls(input logic [7:0] c);
    case (c)
      8'h76, 8'h29, 8'h16, 8'h1E,
      8'h2D, 8'h34, 8'h32: return 1;
      8'h1C, 8'h23:        return 2;
      8'h3B, 8'h4B:        return 3;
      default:             return 0;
    endcase
  endfunction

  function automatic int kidx(input logic [7:0] c);
    case (c)
      8'h76: return 10;
      8'h29: return 9;
      8'h16: return 8;
      8'h1E: return 7;
      8'h2D: return 6;
      8'h34: return 5;
      8'h32: return 4;
      8'h3B: return 3;
      8'h1C: return 2;
      8'h23: return 1;
      8'h4B: return 0;
      default: return -1;
    endcase
  endfunction

  task automatic m_reset();
    for (int r = 0; r < 2; r++) begin
      mq1[r] = {};
      mq2[r] = {};
      mpfx[r] = 0;
      mheld[r] = '0;
      mctrl_ok[r] = 0;
      mctrl[r] = 8'h00;
      mrr[r] = 0;
      mdrop[r] = 0;
      mkv[r] = 0;
      mkc[r] = 8'h00;
    end
  endtask

  task automatic m_push(input int r, input int cls,
                        input logic [7:0] c);
    int sz;
    sz = (cls == 2) ? mq1[r].size() : mq2[r].size();
    if (sz >= 4) begin
      if (mdrop[r] < 255) mdrop[r]++;
    end else if (cls == 2) begin
      mq1[r].push_back(c);
    end else begin
      mq2[r].push_back(c);
    end
  endtask

  task automatic m_step(input int r, input bit sv,
                        input logic [7:0] sc, input bit ft);
    int idx;
    int cls;
    bit was;
    mkv[r] = 0;
    if (ft) begin
      if (mctrl_ok[r]) begin
        mkv[r] = 1; mkc[r] = mctrl[r]; mctrl_ok[r] = 0;
      end else if (mq1[r].size() > 0 &&
                   (!mrr[r] || mq2[r].size() == 0)) begin
        mkv[r] = 1; mkc[r] = mq1[r].pop_front(); mrr[r] = 1;
      end else if (mq2[r].size() > 0) begin
        mkv[r] = 1; mkc[r] = mq2[r].pop_front(); mrr[r] = 0;
      end
    end
    if (sv) begin
      idx = kidx(sc);
      cls = kcls(sc);
      case (mpfx[r])
        0: begin
          if (sc == 8'hF0) mpfx[r] = 1;
          else if (sc == 8'hE0) mpfx[r] = 2;
          else if (idx >= 0) begin
            was = mheld[r][idx];
            mheld[r][idx] = 1'b1;
            if (cls == 1 && !was) begin
              mctrl_ok[r] = 1; mctrl[r] = sc;
            end else if (cls >= 2 && (!was || r == 0)) begin
              m_push(r, cls, sc);
            end
          end
        end
        1: begin
          if (idx >= 0) mheld[r][idx] = 1'b0;
          mpfx[r] = 0;
        end
        2: mpfx[r] = (sc == 8'hF0) ? 3 : 0;
        default: mpfx[r] = 0;
      endcase
    end
  endtask

  task automatic cyc(input bit sv, input logic [7:0] sc,
                     input bit ft);
    scan_valid = sv;
    scan_code  = sc;
    frame_tick = ft;
    for (int r = 0; r < 2; r++) m_step(r, sv, sc, ft);
    @(posedge clock);
    #1;
    scan_valid = 1'b0;
    frame_tick = 1'b0;
    for (int r = 0; r < 2; r++) begin
      chk($sformatf("key_valid%0d", r), 32'(kv[r]), 32'(mkv[r]));
      chk($sformatf("key_code%0d", r), 32'(kc[r]), 32'(mkc[r]));
      chk($sformatf("held%0d", r), 32'(hd[r]), 32'(mheld[r]));
      chk($sformatf("drop%0d", r), 32'(dc[r]), 32'(mdrop[r]));
      if (kv[r]) glog[r].push_back(kc[r]);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    scan_valid = 1'b0;
    frame_tick = 1'b0;
    m_reset();
    #2;
    for (int r = 0; r < 2; r++) begin
      chk("rst_kv", 32'(kv[r]), 32'h0);
      chk("rst_kc", 32'(kc[r]), 32'h0);
      chk("rst_held", 32'(hd[r]), 32'h0);
      chk("rst_drop", 32'(dc[r]), 32'h0);
    end
    reset = 1'b1;
  endtask

  task automatic clr_log();
    glog[0] = {};
    glog[1] = {};
  endtask

  logic [7:0] pool [16] = '{8'h76, 8'h29, 8'h16, 8'h1E, 8'h2D,
                            8'h34, 8'h32, 8'h1C, 8'h23, 8'h3B,
                            8'h4B, 8'hF0, 8'hF0, 8'hF0, 8'hE0,
                            8'h75};

  initial begin
    logic [7:0] b;
    m_reset();
    #12;
    do_reset();
    @(posedge clock); #1;

    // make, grant, break
    cyc(1, 8'h1C, 0);
    chk("a_held", 32'(hd[0][2]), 32'h1);
    cyc(0, 8'h00, 1);
    chk("a_grant_v", 32'(kv[0]), 32'h1);
    chk("a_grant_c", 32'(kc[0]), 32'h1C);
    cyc(1, 8'hF0, 0);
    cyc(1, 8'h1C, 0);
    chk("a_release", 32'(hd[0][2]), 32'h0);

    // typematic repeats into a depth-4 queue
    clr_log();
    repeat (5) cyc(1, 8'h1C, 0);
    chk("rep_drop", 32'(dc[0]), 32'h1);
    chk("norep_drop", 32'(dc[1]), 32'h0);
    cyc(1, 8'hF0, 0);
    cyc(1, 8'h1C, 0);
    repeat (5) cyc(0, 8'h00, 1);
    chk("rep_grants", 32'(glog[0].size()), 32'd4);
    chk("norep_grants", 32'(glog[1].size()), 32'd1);

    // control priority then round robin
    do_reset();
    @(posedge clock); #1;
    clr_log();
    cyc(1, 8'h1C, 0);
    cyc(1, 8'h3B, 0);
    cyc(1, 8'h23, 0);
    cyc(1, 8'h29, 0);
    repeat (4) cyc(0, 8'h00, 1);
    chk("rr_n", 32'(glog[0].size()), 32'd4);
    if (glog[0].size() == 4) begin
      chk("rr_0", 32'(glog[0][0]), 32'h29);
      chk("rr_1", 32'(glog[0][1]), 32'h1C);
      chk("rr_2", 32'(glog[0][2]), 32'h3B);
      chk("rr_3", 32'(glog[0][3]), 32'h23);
    end

    // extended codes are ignored
    do_reset();
    @(posedge clock); #1;
    clr_log();
    cyc(1, 8'hE0, 0);
    cyc(1, 8'h75, 0);
    cyc(1, 8'hE0, 0);
    cyc(1, 8'hF0, 0);
    cyc(1, 8'h75, 0);
    chk("ext_held", 32'(hd[0]), 32'h0);
    cyc(0, 8'h00, 1);
    chk("ext_none", 32'(glog[0].size()), 32'd0);
    cyc(1, 8'h76, 0);
    cyc(0, 8'h00, 1);
    chk("ext_esc", 32'(kc[0]), 32'h76);

    // reset mid-sequence
    cyc(1, 8'hF0, 0);
    do_reset();
    @(posedge clock); #1;
    cyc(1, 8'h23, 0);
    cyc(0, 8'h00, 1);
    chk("mid_code", 32'(kc[0]), 32'h23);
    chk("mid_held", 32'(hd[0][1]), 32'h1);

    // push and pop on a full queue
    do_reset();
    @(posedge clock); #1;
    clr_log();
    repeat (4) cyc(1, 8'h1C, 0);
    cyc(1, 8'h23, 1);
    chk("full_drop", 32'(dc[0]), 32'h0);
    repeat (5) cyc(0, 8'h00, 1);
    chk("full_n", 32'(glog[0].size()), 32'd5);
    if (glog[0].size() == 5)
      chk("full_last", 32'(glog[0][4]), 32'h23);

    // random traffic
    do_reset();
    @(posedge clock); #1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0)
        b = 8'($urandom);
      else
        b = pool[$urandom_range(0, 15)];
      cyc(($urandom_range(0, 1) == 1), b,
          ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 799) == 0) begin
        do_reset();
        @(posedge clock); #1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
